mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi.
- Drives every datapath select and strobe, including the 2-bit aluOp that feeds the ALU control decoder.
- Stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states wait for memReady; 0 = memReady is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-high
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- memReady  in  1  memory has completed the current access this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load qualified by zero
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- memToReg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- regDst  out  1  destination register select: 0 = rt, 1 = rd
- regWrite  out  1  register file write
- aluSrcA  out  1  ALU A select: 0 = PC, 1 = A
- aluSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- aluOp  out  2  to the ALU control decoder: 00 = add, 01 = sub, 10 = funct
- pcSource  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug
- illegalOp  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- State encoding: IDLE = 12, FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, LW_WB = 4, MEM_WR = 5, EXEC_R = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11. Codes 13-15 are unused.
- State register:
  - A cycle with reset = 1 loads IDLE. Reset wins over any transition, including mid-instruction and mid-memory-wait.
  - In IDLE all outputs are 0, state = 12 and illegalOp = 0. These are the reset values of every output.
  - IDLE -> FETCH unconditionally on the next clock edge.
- Outputs are Moore decodes of state, except the memReady gating described below. Any output not listed for a state is 0.
  - FETCH: memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00, pcSource = 00. irWrite and pcWrite are asserted only in the cycle memReady = 1.
  - DECODE: aluSrcA = 0, aluSrcB = 11, aluOp = 00.
  - MEM_ADDR and ADDI_EX: aluSrcA = 1, aluSrcB = 10, aluOp = 00.
  - MEM_RD: memRead = 1, iorD = 1.
  - MEM_WR: memWrite = 1, iorD = 1.
  - LW_WB: regWrite = 1, memToReg = 1, regDst = 0.
  - EXEC_R: aluSrcA = 1, aluSrcB = 00, aluOp = 10.
  - R_WB: regWrite = 1, regDst = 1, memToReg = 0.
  - ADDI_WB: regWrite = 1, regDst = 0, memToReg = 0.
  - BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcWriteCond = 1, pcSource = 01.
  - JUMP: pcWrite = 1, pcSource = 10.
- Transitions:
  - FETCH -> DECODE when memReady = 1, otherwise hold.
  - DECODE dispatches on opcode:
    - 000000 -> EXEC_R
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other opcode -> FETCH, with illegalOp = 1 for exactly that DECODE cycle.
  - MEM_ADDR -> MEM_RD if opcode = 100011, else MEM_WR.
  - MEM_RD -> LW_WB and MEM_WR -> FETCH, each on memReady = 1, otherwise hold. memRead or memWrite stays asserted for the whole wait.
  - EXEC_R -> R_WB, ADDI_EX -> ADDI_WB.
  - LW_WB, R_WB, ADDI_WB, BRANCH and JUMP -> FETCH.
  - Unused state codes -> IDLE next cycle, with all outputs 0.
- opcode is sampled combinationally in DECODE and MEM_ADDR. The IR is stable there because irWrite is 0.
- Latency with memReady always 1 (cycle counts include FETCH):
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle of memReady = 0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- With MEM_WAIT_EN = 0, memReady is treated as 1.
- The controller never asserts memRead and memWrite together.

Test Plan:
- Reset 3 cycles, release, opcode = 000000, memReady = 1 -> state 12, 0, 1, 6, 7, 0. aluOp = 10 in state 6. regWrite = 1 and regDst = 1 in state 7 only.
- lw (100011) with memReady held low 2 cycles in FETCH and 1 cycle in MEM_RD -> states 0, 0, 0, 1, 2, 3, 3, 4, 0. irWrite and pcWrite pulse only on the third FETCH cycle. memToReg = 1 in state 4.
- sw (101011) -> states 0, 1, 2, 5, 0. memWrite = 1 and iorD = 1 in state 5. regWrite is never asserted.
- beq (000100) -> BRANCH with aluOp = 01, pcWriteCond = 1, pcSource = 01. j (000010) -> JUMP with pcWrite = 1, pcSource = 10. Both return to FETCH next cycle.
- opcode 111111 -> illegalOp is a 1-cycle pulse in DECODE, next state is 0, and no regWrite or memWrite is issued.
- reset asserted while in MEM_RD waiting on memReady -> next state is 12 with all outputs 0, then 0. Separately, force state 14 via the bench -> next state is 12.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and strobe.
module mc_main_ctrl #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] pcSource,
   output logic [3:0] state,
   output logic       illegalOp
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_LW_WB    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11,
      S_IDLE     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Plain 4-bit register so the unused codes 13-15 are representable and recoverable.
   logic [3:0] state_q, state_d;
   logic       mem_rdy;

   assign mem_rdy = MEM_WAIT_EN ? memReady : 1'b1;
   assign state   = state_q;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // The zero flag qualifies pcWriteCond in the datapath, not the sequencing here.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      // NOTE: every output and the next state get a default before the case,
      // so no path through the block can leave a latch behind.
      state_d     = state_q;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      illegalOp   = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = mem_rdy;
            pcWrite = mem_rdy;
            if (mem_rdy) state_d = S_DECODE;
         end

         S_DECODE: begin
            aluSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:      state_d = S_EXEC_R;
               OP_LW, OP_SW:  state_d = S_MEM_ADDR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_ADDI:       state_d = S_ADDI_EX;
               default: begin
                  state_d   = S_FETCH;
                  illegalOp = 1'b1;
               end
            endcase
         end

         S_MEM_ADDR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (mem_rdy) state_d = S_LW_WB;
         end

         S_MEM_WR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            if (mem_rdy) state_d = S_FETCH;
         end

         S_LW_WB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
            state_d  = S_FETCH;
         end

         S_EXEC_R: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
            state_d = S_R_WB;
         end

         S_R_WB: begin
            regWrite = 1'b1;
            regDst   = 1'b1;
            state_d  = S_FETCH;
         end

         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'b01;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            state_d     = S_FETCH;
         end

         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
            state_d  = S_FETCH;
         end

         S_ADDI_EX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = S_ADDI_WB;
         end

         S_ADDI_WB: begin
            regWrite = 1'b1;
            state_d  = S_FETCH;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: the driver pushes the expected state and
// control word for every cycle, a negedge monitor pops and compares.
module tb_mc_main_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       memReady = 1'b1;
   logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
   logic [1:0] aluSrcB, aluOp, pcSource;
   logic [3:0] state;

   always #5 clk = ~clk;

   mc_main_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .pcSource(pcSource), .state(state), .illegalOp(illegalOp)
   );

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctl_t;

   typedef struct packed {
      logic [3:0] st;
      ctl_t       ctl;
   } exp_t;

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                          LW_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, R_WB = 4'd7,
                          BRANCH = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11,
                          IDLE = 4'd12;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   ctl_t act_c;

   assign act_c = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                   regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h, want %h", name, cycle, act, want);
      end
   endtask

   // Reference control word for a state, written straight from the state table.
   function automatic ctl_t ref_ctl(input logic [3:0] st, input logic mr, input logic ill);
      ctl_t c = '0;
      case (st)
         FETCH:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
         DECODE:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
         MEM_ADDR, ADDI_EX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         MEM_RD:  begin c.mem_read = 1; c.ior_d = 1; end
         MEM_WR:  begin c.mem_write = 1; c.ior_d = 1; end
         LW_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
         EXEC_R:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         R_WB:    begin c.reg_write = 1; c.reg_dst = 1; end
         ADDI_WB: c.reg_write = 1;
         BRANCH:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
         JUMP:    begin c.pc_write = 1; c.pc_source = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   // One clock: drive inputs just after the edge and record what this cycle must show.
   task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic ill);
      exp_t e;
      @(posedge clk); #1;
      reset    = rst;
      opcode   = op;
      memReady = mr;
      zero     = 1'($urandom);
      e.st  = st;
      e.ctl = ref_ctl(st, mr, ill);
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, opcode, 1'($urandom), IDLE, 1'b0);
      step(1'b0, 6'd0, 1'b1, IDLE, 1'b0);
   endtask

   // Instruction-level model: each phase lasts one cycle plus its memory wait cycles.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      for (int i = 0; i <= fw; i++) step(1'b0, op, i == fw, FETCH, 1'b0);
      step(1'b0, op, 1'($urandom), DECODE, !legal(op));
      case (op)
         6'b000000: begin
            step(1'b0, op, 1'($urandom), EXEC_R, 1'b0);
            step(1'b0, op, 1'($urandom), R_WB, 1'b0);
         end
         6'b100011: begin
            step(1'b0, op, 1'($urandom), MEM_ADDR, 1'b0);
            for (int i = 0; i <= mw; i++) step(1'b0, op, i == mw, MEM_RD, 1'b0);
            step(1'b0, op, 1'($urandom), LW_WB, 1'b0);
         end
         6'b101011: begin
            step(1'b0, op, 1'($urandom), MEM_ADDR, 1'b0);
            for (int i = 0; i <= mw; i++) step(1'b0, op, i == mw, MEM_WR, 1'b0);
         end
         6'b000100: step(1'b0, op, 1'($urandom), BRANCH, 1'b0);
         6'b000010: step(1'b0, op, 1'($urandom), JUMP, 1'b0);
         6'b001000: begin
            step(1'b0, op, 1'($urandom), ADDI_EX, 1'b0);
            step(1'b0, op, 1'($urandom), ADDI_WB, 1'b0);
         end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      cycle++;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("trace", {state, act_c}, {e.st, e.ctl});
         check("rd_wr_excl", {19'd0, memRead & memWrite}, 20'd0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [5:0] ops[6];
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

      do_reset(3);
      run_instr(6'b000000, 0, 0);
      run_instr(6'b100011, 2, 1);
      run_instr(6'b101011, 0, 0);
      run_instr(6'b000100, 0, 0);
      run_instr(6'b000010, 0, 0);
      run_instr(6'b001000, 0, 0);
      run_instr(6'b111111, 0, 0);

      // Reset lands while MEM_RD is still waiting on memory.
      step(1'b0, 6'b100011, 1'b1, FETCH, 1'b0);
      step(1'b0, 6'b100011, 1'b0, DECODE, 1'b0);
      step(1'b0, 6'b100011, 1'b0, MEM_ADDR, 1'b0);
      step(1'b0, 6'b100011, 1'b0, MEM_RD, 1'b0);
      step(1'b1, 6'b100011, 1'b0, MEM_RD, 1'b0);
      step(1'b0, 6'b100011, 1'b0, IDLE, 1'b0);
      run_instr(6'b000010, 0, 0);

      // Push the register into unused code 14 and expect recovery through IDLE.
      force dut.state_d = 4'd14;
      @(posedge clk); #1;
      release dut.state_d;
      opcode = ~opcode;
      memReady = 1'b1;
      begin
         exp_t e;
         e.st = 4'd14;
         e.ctl = '0;
         exp_q.push_back(e);
      end
      step(1'b0, 6'd0, 1'b1, IDLE, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         int sel;
         sel = $urandom_range(0, 6);
         op  = (sel == 6) ? 6'($urandom) : ops[sel];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk); #1;
      check("drain", 20'(exp_q.size()), 20'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
